down_counter: RTL and testbench
===============================

DOWN_COUNTER -- requirements
Module: down_counter

Interface
REQ-001 Parameter: WIDTH, default 4, counter bit width (legal range 2..32).
REQ-002 clk  input  1  rising-edge clock; the block's only clock.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 load  input  1  load request; samples load_val on the rising edge.
REQ-005 load_val  input  WIDTH  start and reload value.
REQ-006 en  input  1  count enable; one decrement per enabled cycle.
REQ-007 count  output  WIDTH  registered current count.
REQ-008 zero  output  1  combinational flag, high when count == 0.
REQ-009 busy  output  1  registered flag, high when the state is RUN.
REQ-010 done  output  1  registered single-cycle pulse on terminal count.

Function
REQ-011 The block SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-012 A load in any state SHALL take priority over en: count <= load_val and reload_reg <= load_val on the next edge.
REQ-013 A load with load_val != 0 SHALL move the FSM to RUN; a load with load_val == 0 SHALL move it to DONE and pulse done in that cycle.
REQ-014 In RUN with en=1 and load=0, count SHALL decrement by 1 per edge, with one-cycle latency.
REQ-015 In RUN with en=0 and load=0, count and state SHALL hold.
REQ-016 On the edge where count goes 1 -> 0, done SHALL be 1 for exactly that cycle, coincident with count == 0.
REQ-017 Arithmetic SHALL be unsigned modulo 2^WIDTH; in DONE, count SHALL never underflow below 0 or wrap to all-ones.
REQ-018 In IDLE and DONE, en SHALL be ignored and count SHALL hold.
REQ-019 done SHALL be 0 in every cycle not specified by REQ-013 and REQ-016 (or by REQ-025 when enabled).
REQ-020 busy SHALL be 1 exactly while the state is RUN; it SHALL drop on the same edge that sets count to 0 when the FSM enters DONE.

Reset
REQ-021 rst=1 SHALL override load and en on the same edge.
REQ-022 Reset SHALL set count=0, reload_reg=0, state=IDLE, busy=0 and done=0; zero SHALL therefore read 1.
REQ-023 Reset mid-RUN SHALL abort the count with no done pulse.

Configuration
REQ-024 The macro DOWN_COUNTER_AUTORELOAD_EN SHALL select periodic auto-reload mode.
REQ-025 With the macro defined: at count 1 -> 0 in RUN, the FSM SHALL stay in RUN; the next enabled edge SHALL load count <= reload_reg; the period SHALL be (reload_reg + 1) enabled cycles, with done pulsing at each 0.
REQ-026 Without the macro: the FSM SHALL enter DONE at count 0 and hold until a load or reset; reload_reg MAY be optimised away.
REQ-027 A load_val of 0 SHALL behave as REQ-013 in both configurations.

Structure
REQ-028 Package down_counter_pkg SHALL hold the state enum typedef (IDLE/RUN/DONE) and the constant DEFAULT_WIDTH = 4.
REQ-029 The block SHALL be a single module; no sub-module is required.

Verification (WIDTH=4)
REQ-030 rst=1 for 2 cycles -> count=0, zero=1, busy=0, done=0; load/en driven high during reset are ignored.
REQ-031 load=1, load_val=5, then en=1 -> count 5,4,3,2,1,0; done=1 only in the count=0 cycle; busy falls on that edge; count holds 0 for 5 more cycles (macro off).
REQ-032 Counting from 5 with en=0 for 3 cycles at count=3 -> count stays 3 and busy stays 1; resuming en gives 2,1,0.
REQ-033 At count=2, load=1, en=1, load_val=9 -> next count=9, no decrement that cycle; counts on to 0 with a single done pulse.
REQ-034 load_val=0 -> next cycle count=0, state DONE, done=1 for one cycle, busy=0; rst asserted at count=4 -> count=0 next edge, no done pulse.
REQ-035 Macro on, load_val=2, en=1 held -> count 2,1,0,2,1,0,... with done=1 at each 0 and busy continuously 1.

Source files
------------

// File: rtl/down_counter_pkg.sv
// Shared definitions for the down_counter block: the FSM state encoding
// and the default counter width.
package down_counter_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/down_counter.sv
// down_counter: loadable down counter with IDLE/RUN/DONE control FSM.
// A load always wins over en. A non-zero load starts a run. A zero load
// jumps straight to DONE with a done pulse. done pulses on the 1 -> 0 step.
//
// Build option: define DOWN_COUNTER_AUTORELOAD_EN for periodic mode. In that
// mode, reaching 0 keeps the FSM in RUN, and the next enabled edge reloads the
// last loaded value. Without the macro, the FSM parks in DONE at 0.
module down_counter
    import down_counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic             zero,
    output logic             busy,
    output logic             done
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] count_next;
    logic             busy_next;
    logic             done_next;
    logic             at_one;
    logic             at_zero;

`ifdef DOWN_COUNTER_AUTORELOAD_EN
    logic [WIDTH-1:0] reload_reg;
    logic [WIDTH-1:0] reload_next;
`endif

    assign at_one  = (count == ONE);
    assign at_zero = (count == '0);
    assign zero    = at_zero;

    // State register plus registered count/flags; reset aborts any run silently
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            count      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
`ifdef DOWN_COUNTER_AUTORELOAD_EN
            reload_reg <= '0;
`endif
        end else begin
            state      <= state_next;
            count      <= count_next;
            busy       <= busy_next;
            done       <= done_next;
`ifdef DOWN_COUNTER_AUTORELOAD_EN
            reload_reg <= reload_next;
`endif
        end
    end

    // Next-state logic: load decides the state outright, otherwise only RUN moves
    always_comb begin
        state_next = state;
        if (load) begin
            state_next = (load_val != '0) ? RUN : DONE;
        end else begin
            case (state)
                RUN: begin
`ifdef DOWN_COUNTER_AUTORELOAD_EN
                    state_next = RUN;
`else
                    if (en && (at_one || at_zero)) begin
                        state_next = DONE;
                    end
`endif
                end
                IDLE:    state_next = IDLE;
                DONE:    state_next = DONE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Output logic: next count, done pulse, and busy follow from the state move
    always_comb begin
        count_next = count;
        done_next  = 1'b0;
        busy_next  = (state_next == RUN);
`ifdef DOWN_COUNTER_AUTORELOAD_EN
        reload_next = reload_reg;
`endif
        if (load) begin
            count_next = load_val;
            done_next  = (load_val == '0);
`ifdef DOWN_COUNTER_AUTORELOAD_EN
            reload_next = load_val;
`endif
        end else if ((state == RUN) && en) begin
`ifdef DOWN_COUNTER_AUTORELOAD_EN
            if (at_zero) begin
                count_next = reload_reg;
            end else begin
                count_next = count - ONE;
                done_next  = at_one;
            end
`else
            if (!at_zero) begin
                count_next = count - ONE;
                done_next  = at_one;
            end
`endif
        end
    end

endmodule

// File: tb/tb_down_counter.sv
// Testbench for down_counter (WIDTH=4). Directed scenarios with literal
// expectations, then randomized traffic. A behavioural model is checked
// on every falling edge. Honours DOWN_COUNTER_AUTORELOAD_EN like the RTL.
module tb_down_counter;

    localparam int W    = 4;
    localparam int MASK = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] load_val = '0;
    logic         en = 1'b0;
    logic [W-1:0] count;
    logic         zero;
    logic         busy;
    logic         done;

    int vectors     = 0;
    int miscompares = 0;

    // Behavioural model state
    int mCount  = 0;
    int mReload = 0;
    bit mRun    = 0;
    bit mDone   = 0;
    bit mValid  = 0;

    down_counter #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (load_val),
        .en       (en),
        .count    (count),
        .zero     (zero),
        .busy     (busy),
        .done     (done)
    );

    // Free-running clock, 10 time units per period
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic l, input int lv, input logic e);
        rst      = r;
        load     = l;
        load_val = W'(lv);
        en       = e;
        @(posedge clk);
        #1;
    endtask

    // Reference model: counter semantics described directly in integers
    always @(posedge clk) begin
        if (rst) begin
            mCount = 0; mReload = 0; mRun = 0; mDone = 0; mValid = 1;
        end else if (load) begin
            mCount  = int'(load_val);
            mReload = int'(load_val);
            mRun    = (load_val != 0);
            mDone   = (load_val == 0);
        end else if (mRun && en) begin
            if (mCount == 0) begin
                mCount = mReload;
                mDone  = 0;
            end else begin
                mCount = (mCount - 1) & MASK;
                mDone  = (mCount == 0);
`ifndef DOWN_COUNTER_AUTORELOAD_EN
                if (mDone) mRun = 0;
`endif
            end
        end else begin
            mDone = 0;
        end
    end

    // Compare process: every falling edge once the model has seen a reset
    always @(negedge clk) begin
        if (mValid) begin
            checkOutput("model.count", count, mCount);
            checkOutput("model.zero",  zero,  (mCount == 0));
            checkOutput("model.busy",  busy,  mRun);
            checkOutput("model.done",  done,  mDone);
        end
    end

    initial begin
        int doneCount;

        // Reset with load/en forced high: both must be ignored
        applyStimulus(1, 1, 7, 1);
        applyStimulus(1, 1, 7, 1);
        checkOutput("rst.count", count, 0);
        checkOutput("rst.zero",  zero,  1);
        checkOutput("rst.busy",  busy,  0);
        checkOutput("rst.done",  done,  0);

`ifdef DOWN_COUNTER_AUTORELOAD_EN
        // Periodic mode: load 2 and hold en -> 1,0,2,1,0,2,...
        applyStimulus(0, 1, 2, 0);
        checkOutput("ar.load.count", count, 2);
        for (int i = 0; i < 9; i++) begin
            int exp;
            exp = (i % 3 == 0) ? 1 : (i % 3 == 1) ? 0 : 2;
            applyStimulus(0, 0, 0, 1);
            checkOutput("ar.count", count, exp);
            checkOutput("ar.done",  done,  (exp == 0));
            checkOutput("ar.busy",  busy,  1);
        end
`else
        // Load 5 then count to 0 with one done pulse, then hold at 0
        applyStimulus(0, 1, 5, 0);
        checkOutput("run5.load.count", count, 5);
        checkOutput("run5.load.busy",  busy,  1);
        for (int i = 4; i >= 0; i--) begin
            applyStimulus(0, 0, 0, 1);
            checkOutput("run5.count", count, i);
            checkOutput("run5.done",  done,  (i == 0));
            checkOutput("run5.busy",  busy,  (i != 0));
        end
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 0, 0, 1);
            checkOutput("hold0.count", count, 0);
            checkOutput("hold0.done",  done,  0);
        end

        // Pause at 3 for three cycles, then resume
        applyStimulus(0, 1, 5, 1);
        applyStimulus(0, 0, 0, 1);
        applyStimulus(0, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 0, 0);
            checkOutput("pause.count", count, 3);
            checkOutput("pause.busy",  busy,  1);
        end
        for (int i = 2; i >= 0; i--) begin
            applyStimulus(0, 0, 0, 1);
            checkOutput("resume.count", count, i);
            checkOutput("resume.done",  done,  (i == 0));
        end

        // Reload at 2 with en high: load wins, then a single done on the way down
        applyStimulus(0, 1, 5, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 1);
        checkOutput("reload.pre.count", count, 2);
        applyStimulus(0, 1, 9, 1);
        checkOutput("reload.count", count, 9);
        checkOutput("reload.done",  done,  0);
        doneCount = 0;
        for (int i = 0; i < 12; i++) begin
            applyStimulus(0, 0, 0, 1);
            if (done) doneCount++;
        end
        checkOutput("reload.final", count, 0);
        checkOutput("reload.pulses", doneCount, 1);
`endif

        // Zero load: straight to DONE with a pulse
        applyStimulus(0, 1, 0, 1);
        checkOutput("zload.count", count, 0);
        checkOutput("zload.done",  done,  1);
        checkOutput("zload.busy",  busy,  0);
        applyStimulus(0, 0, 0, 1);
        checkOutput("zload.after.done",  done,  0);
        checkOutput("zload.after.count", count, 0);

        // Reset mid-run at count 4: aborted, no done
        applyStimulus(0, 1, 6, 0);
        applyStimulus(0, 0, 0, 1);
        applyStimulus(0, 0, 0, 1);
        checkOutput("abort.pre.count", count, 4);
        applyStimulus(1, 0, 0, 1);
        checkOutput("abort.count", count, 0);
        checkOutput("abort.done",  done,  0);
        checkOutput("abort.busy",  busy,  0);

        // Randomized traffic, checked by the compare process against the model
        for (int i = 0; i < 800; i++) begin
            logic r, l, e;
            int lv;
            r  = ($urandom_range(0, 59) == 0);
            l  = ($urandom_range(0, 9) == 0);
            e  = ($urandom_range(0, 3) != 0);
            lv = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, MASK));
            applyStimulus(r, l, lv, e);
        end

        applyStimulus(0, 0, 0, 0);
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
